// File: rtl/fence_wfi_sequencer.sv
// Stalls execute while fence.i (drain, D-flush, I-inval, refetch), wfi (park until irq) or halt (drain, stop) complete.
// Min fence.i latency 5 cycles; cache requests held until acknowledged, dbus_busy holds drain states indefinitely.
module fence_wfi_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ex_valid,
    input  logic             ifence,
    input  logic             wfi,
    input  logic             halt,
    input  logic             dbus_busy,
    input  logic             irq_pending,
    output logic             dflush_req,
    input  logic             dflush_done,
    output logic             iinval_req,
    input  logic             iinval_done,
    output logic             stall,
    output logic             flush_fetch,
    output logic             halted,
    output logic [CNT_W-1:0] wfi_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_DFLUSH,
        S_IINVAL,
        S_REFETCH,
        S_WFI,
        S_HALT_DRAIN,
        S_HALTED
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   stall_raw;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_raw = 1'b0;
        case (state)
            S_IDLE: begin
                stall_raw = ex_valid & (halt | ifence | (wfi & ~irq_pending));
                if (ex_valid) begin
                    if (halt) begin
                        state_nxt = S_HALT_DRAIN;
                    end else if (ifence) begin
                        state_nxt = S_DRAIN;
                    end else if (wfi && !irq_pending) begin
                        state_nxt = S_WFI;
                    end
                end
            end
            S_DRAIN: begin
                stall_raw = 1'b1;
                if (!dbus_busy) state_nxt = S_DFLUSH;
            end
            S_DFLUSH: begin
                stall_raw = 1'b1;
                if (dflush_done) state_nxt = S_IINVAL;
            end
            S_IINVAL: begin
                stall_raw = 1'b1;
                if (iinval_done) state_nxt = S_REFETCH;
            end
            // fence.i retires here while fetch is redirected
            S_REFETCH: begin
                state_nxt = S_IDLE;
            end
            S_WFI: begin
                stall_raw = ~irq_pending;
                if (irq_pending) state_nxt = S_IDLE;
            end
            S_HALT_DRAIN: begin
                stall_raw = 1'b1;
                if (!dbus_busy) state_nxt = S_HALTED;
            end
            S_HALTED: begin
                stall_raw = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // stall has a combinational path from the strobes, so mask it during reset
    assign stall       = stall_raw & ~RST;
    assign dflush_req  = (state == S_DFLUSH);
    assign iinval_req  = (state == S_IINVAL);
    assign flush_fetch = (state == S_REFETCH);
    assign halted      = (state == S_HALTED);

    // The wake cycle itself is not counted: only cycles still parked
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wfi_cycles <= '0;
        end else if (state == S_WFI && !irq_pending && wfi_cycles != {CNT_W{1'b1}}) begin
            wfi_cycles <= wfi_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_fence_wfi_sequencer.sv
// Directed bench for fence_wfi_sequencer: fence.i, wfi, halt, reset and spurious-ack cases.
module tb_fence_wfi_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ex_valid, ifence, wfi, halt, dbus_busy, irq_pending;
    logic       dflush_done, iinval_done;
    logic       dflush_req, iinval_req, stall, flush_fetch, halted;
    logic [3:0] wfi_cycles;

    int checks = 0;
    int errors = 0;
    int stall_cnt;
    int ff_cnt;

    always #5 CLK = ~CLK;

    fence_wfi_sequencer #(.CNT_W(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ex_valid   (ex_valid),
        .ifence     (ifence),
        .wfi        (wfi),
        .halt       (halt),
        .dbus_busy  (dbus_busy),
        .irq_pending(irq_pending),
        .dflush_req (dflush_req),
        .dflush_done(dflush_done),
        .iinval_req (iinval_req),
        .iinval_done(iinval_done),
        .stall      (stall),
        .flush_fetch(flush_fetch),
        .halted     (halted),
        .wfi_cycles (wfi_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic clr();
        ex_valid    = 1'b0;
        ifence      = 1'b0;
        wfi         = 1'b0;
        halt        = 1'b0;
        dbus_busy   = 1'b0;
        irq_pending = 1'b0;
        dflush_done = 1'b0;
        iinval_done = 1'b0;
    endtask

    initial begin
        // Reset state, with a live strobe that must not leak onto stall
        RST = 1'b1;
        clr();
        ex_valid = 1'b1;
        halt     = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dflush", 32'(dflush_req), 32'd0);
        chk("rst_iinval", 32'(iinval_req), 32'd0);
        chk("rst_ff", 32'(flush_fetch), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_wc", 32'(wfi_cycles), 32'd0);
        cyc(); RST = 1'b0; clr(); #1;
        chk("idle_stall", 32'(stall), 32'd0);

        // Strobes without ex_valid are ignored
        cyc(); halt = 1'b1; ifence = 1'b1; wfi = 1'b1; #1;
        chk("noval_stall", 32'(stall), 32'd0);
        cyc(); clr(); #1;
        chk("noval_stall2", 32'(stall), 32'd0);
        chk("noval_dflush", 32'(dflush_req), 32'd0);
        chk("noval_halted", 32'(halted), 32'd0);

        // fence.i: busy 3 cycles in DRAIN, each ack on the second request cycle
        cyc(); ex_valid = 1'b1; ifence = 1'b1; dbus_busy = 1'b1; #1;
        chk("fi_trig_stall", 32'(stall), 32'd1);
        stall_cnt = int'(stall);
        ff_cnt    = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(); clr();
            dbus_busy   = (k <= 3);
            dflush_done = (k == 6);
            iinval_done = (k == 8);
            #1;
            chk($sformatf("fi_stall_k%0d", k), 32'(stall), 32'(k <= 8));
            chk($sformatf("fi_dflush_k%0d", k), 32'(dflush_req), 32'(k == 5 || k == 6));
            chk($sformatf("fi_iinval_k%0d", k), 32'(iinval_req), 32'(k == 7 || k == 8));
            chk($sformatf("fi_ff_k%0d", k), 32'(flush_fetch), 32'(k == 9));
            stall_cnt += int'(stall);
            ff_cnt    += int'(flush_fetch);
        end
        chk("fi_stall_total", 32'(stall_cnt), 32'd9);
        chk("fi_ff_total", 32'(ff_cnt), 32'd1);

        // wfi: parked 10 cycles, wake with zero-cycle stall release
        cyc(); clr(); ex_valid = 1'b1; wfi = 1'b1; #1;
        chk("wfi_trig_stall", 32'(stall), 32'd1);
        chk("wfi_trig_wc", 32'(wfi_cycles), 32'd0);
        for (int k = 1; k <= 11; k++) begin
            cyc(); clr(); irq_pending = (k == 11); #1;
            chk($sformatf("wfi_stall_k%0d", k), 32'(stall), 32'(k != 11));
            if (k == 5)  chk("wfi_wc_mid", 32'(wfi_cycles), 32'd4);
            if (k == 11) chk("wfi_wc_wake", 32'(wfi_cycles), 32'd10);
        end
        cyc(); clr(); #1;
        chk("wfi_after_stall", 32'(stall), 32'd0);
        chk("wfi_after_wc", 32'(wfi_cycles), 32'd10);

        // wfi with interrupt already pending retires as a nop
        cyc(); ex_valid = 1'b1; wfi = 1'b1; irq_pending = 1'b1; #1;
        chk("wfi_nop_stall", 32'(stall), 32'd0);
        cyc(); clr(); #1;
        chk("wfi_nop_stall2", 32'(stall), 32'd0);
        chk("wfi_nop_wc", 32'(wfi_cycles), 32'd10);

        // Spurious acknowledges in IDLE
        cyc(); dflush_done = 1'b1; iinval_done = 1'b1; #1;
        chk("sp_idle_dflush", 32'(dflush_req), 32'd0);
        chk("sp_idle_stall", 32'(stall), 32'd0);
        cyc(); clr(); #1;
        chk("sp_idle_dflush2", 32'(dflush_req), 32'd0);
        chk("sp_idle_iinval2", 32'(iinval_req), 32'd0);
        chk("sp_idle_ff2", 32'(flush_fetch), 32'd0);
        chk("sp_idle_stall2", 32'(stall), 32'd0);

        // Spurious acknowledges in WFI
        cyc(); ex_valid = 1'b1; wfi = 1'b1; #1;
        chk("sp_wfi_trig", 32'(stall), 32'd1);
        cyc(); clr(); dflush_done = 1'b1; iinval_done = 1'b1; #1;
        chk("sp_wfi_stall", 32'(stall), 32'd1);
        cyc(); clr(); #1;
        chk("sp_wfi_stall2", 32'(stall), 32'd1);
        chk("sp_wfi_dflush", 32'(dflush_req), 32'd0);
        chk("sp_wfi_iinval", 32'(iinval_req), 32'd0);
        cyc(); irq_pending = 1'b1; #1;
        chk("sp_wfi_wake", 32'(stall), 32'd0);
        cyc(); clr(); #1;
        chk("sp_wfi_wc", 32'(wfi_cycles), 32'd12);

        // Asynchronous reset in the middle of IINVAL
        cyc(); ex_valid = 1'b1; ifence = 1'b1; #1;
        chk("ar_trig", 32'(stall), 32'd1);
        cyc(); clr(); #1;
        chk("ar_drain_stall", 32'(stall), 32'd1);
        cyc(); dflush_done = 1'b1; #1;
        chk("ar_dflush", 32'(dflush_req), 32'd1);
        cyc(); clr(); #1;
        chk("ar_iinval", 32'(iinval_req), 32'd1);
        #2;
        RST = 1'b1; ex_valid = 1'b1; ifence = 1'b1;
        #1;
        chk("ar_iinval_drop", 32'(iinval_req), 32'd0);
        chk("ar_dflush_drop", 32'(dflush_req), 32'd0);
        chk("ar_stall", 32'(stall), 32'd0);
        chk("ar_ff", 32'(flush_fetch), 32'd0);
        chk("ar_halted", 32'(halted), 32'd0);
        chk("ar_wc", 32'(wfi_cycles), 32'd0);
        cyc();
        cyc(); RST = 1'b0; clr(); #1;
        chk("ar_rel_stall", 32'(stall), 32'd0);
        chk("ar_rel_iinval", 32'(iinval_req), 32'd0);
        cyc(); #1;
        chk("ar_idle_iinval", 32'(iinval_req), 32'd0);
        chk("ar_idle_dflush", 32'(dflush_req), 32'd0);
        chk("ar_idle_wc", 32'(wfi_cycles), 32'd0);

        // Counter saturation at 4 bits
        cyc(); ex_valid = 1'b1; wfi = 1'b1; #1;
        chk("sat_trig", 32'(stall), 32'd1);
        for (int k = 1; k <= 21; k++) begin
            cyc(); clr(); irq_pending = (k == 21); #1;
            chk($sformatf("sat_stall_k%0d", k), 32'(stall), 32'(k != 21));
            if (k == 15) chk("sat_wc_14", 32'(wfi_cycles), 32'd14);
            if (k >= 16) chk($sformatf("sat_wc_k%0d", k), 32'(wfi_cycles), 32'd15);
        end
        cyc(); clr(); #1;
        chk("sat_after_wc", 32'(wfi_cycles), 32'd15);
        chk("sat_after_stall", 32'(stall), 32'd0);

        // halt wins over ifence; busy during trigger and first drain cycle
        cyc(); ex_valid = 1'b1; halt = 1'b1; ifence = 1'b1; dbus_busy = 1'b1; #1;
        chk("h_trig_stall", 32'(stall), 32'd1);
        chk("h_trig_halted", 32'(halted), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc(); clr();
            dbus_busy = (k == 1);
            if (k >= 4) begin
                ex_valid    = 1'b1;
                ifence      = 1'b1;
                wfi         = 1'b1;
                halt        = (k == 5);
                irq_pending = (k >= 6);
                dflush_done = 1'b1;
            end
            #1;
            chk($sformatf("h_halted_k%0d", k), 32'(halted), 32'(k >= 3));
            chk($sformatf("h_stall_k%0d", k), 32'(stall), 32'd1);
            chk($sformatf("h_dflush_k%0d", k), 32'(dflush_req), 32'd0);
            chk($sformatf("h_iinval_k%0d", k), 32'(iinval_req), 32'd0);
            chk($sformatf("h_ff_k%0d", k), 32'(flush_fetch), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
